// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Holds the reset fetch address, the nop encoding and the buffered-word record.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch unit: imem request/response, redirect and F->D handshake.
// master = fetch unit side, slave = memory / pipeline side.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        F_valid;
  logic [31:0] F_PC;
  logic [31:0] F_instruction;
  logic        D_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output F_valid, F_PC, F_instruction,
    input  D_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  F_valid, F_PC, F_instruction,
    output D_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with push/pop/flush and full/empty/count status.
// Head word is readable combinationally; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Flush wins over a same-cycle push so a discarded word never lands.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests, buffers
// returned words with their PCs and presents them to decode; redirects drop wrong-path words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic          active_q, active_d;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] occ;
  logic          pcf_full, pcf_empty;
  logic          of_full, of_empty;
  logic [31:0]   pcf_head;
  logic [EW-1:0] of_head_bits;
  fetch_entry_t  of_head;
  fetch_entry_t  of_push;

  logic redirect, deq, space_ok, req_valid, accept, rsp_fire, keep_rsp;

  assign redirect = bus.redirect_valid;
  assign deq      = !of_empty && bus.D_ready && !redirect;

  // The slot freed by this cycle's dequeue is credited so a 1-cycle memory sustains 1 IPC.
  assign space_ok  = ((int'(out_cnt) + int'(occ) - int'(deq)) < BUF_DEPTH)
                     && !pcf_full && (!of_full || deq);
  assign req_valid = active_q && !redirect && space_ok;
  assign accept    = req_valid && bus.imem_req_ready;
  assign rsp_fire  = bus.imem_rsp_valid && !pcf_empty;
  assign keep_rsp  = rsp_fire && !redirect && (kill_cnt_q == '0);

  assign of_push = '{pc: pcf_head, instr: bus.imem_rsp_data};
  assign of_head = fetch_entry_t'(of_head_bits);

  // PCs of accepted requests; its occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (BUF_DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pc_q),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head_data (pcf_head),
    .full      (pcf_full),
    .empty     (pcf_empty),
    .count     (out_cnt)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep_rsp),
    .push_data (of_push),
    .pop       (deq),
    .flush     (redirect),
    .head_data (of_head_bits),
    .full      (of_full),
    .empty     (of_empty),
    .count     (occ)
  );

  always_comb begin
    pc_d       = pc_q;
    kill_cnt_d = kill_cnt_q;
    active_d   = 1'b1;
    if (redirect) begin
      pc_d       = word_align(bus.redirect_pc);
      // Everything still in flight is wrong-path; a response arriving now is dropped too.
      kill_cnt_d = out_cnt - CW'(rsp_fire);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (rsp_fire && (kill_cnt_q != '0)) kill_cnt_d = kill_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      kill_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      kill_cnt_q <= kill_cnt_d;
      active_q   <= active_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.F_valid        = !of_empty;
  assign bus.F_PC           = of_empty ? 32'h0 : of_head.pc;
  assign bus.F_instruction  = of_empty ? NOP : of_head.instr;

endmodule
